// File: rtl/pwm_gen_core.sv
// Multi-channel PWM generator with a shared prescaled period counter.
// Configuration passes through shadow registers that only load at a period boundary while running.
module pwm_gen_core #(
    parameter int unsigned CNT_WIDTH = 16,
    parameter int unsigned NUM_CH    = 4,
    parameter int unsigned PRE_WIDTH = 8
) (
    input  logic                        ACLK,
    input  logic                        ARESET,
    input  logic                        cfg_enable,
    input  logic [NUM_CH-1:0]           cfg_invert,
    input  logic [PRE_WIDTH-1:0]        cfg_prescale,
    input  logic [CNT_WIDTH-1:0]        cfg_period,
    input  logic [NUM_CH*CNT_WIDTH-1:0] cfg_duty,
    input  logic                        cfg_update,
    output logic [NUM_CH-1:0]           pwm_out,
    output logic                        period_tick,
    output logic                        update_done
);

    typedef enum logic {StIdle, StRun} state_e;

    state_e                      state_q, state_d;
    logic [PRE_WIDTH-1:0]        pre_cnt_q, pre_cnt_d;
    logic [CNT_WIDTH-1:0]        cnt_q, cnt_d;
    logic [PRE_WIDTH-1:0]        pre_sh_q, pre_sh_d;
    logic [CNT_WIDTH-1:0]        per_sh_q, per_sh_d;
    logic [NUM_CH*CNT_WIDTH-1:0] duty_sh_q, duty_sh_d;
    logic [NUM_CH-1:0]           inv_sh_q, inv_sh_d;
    logic                        pending_q, pending_d;
    logic [NUM_CH-1:0]           pwm_q, pwm_d;
    logic                        period_tick_q, period_tick_d;
    logic                        update_done_q, update_done_d;

    logic              tick;
    logic              wrap;
    logic [NUM_CH-1:0] active;

    assign tick = (pre_cnt_q == pre_sh_q);
    assign wrap = tick && (cnt_q == per_sh_q);

    always_comb begin
        active = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            active[i] = cnt_q < duty_sh_q[i*CNT_WIDTH +: CNT_WIDTH];
        end
    end

    always_comb begin
        state_d       = state_q;
        pre_cnt_d     = pre_cnt_q;
        cnt_d         = cnt_q;
        pre_sh_d      = pre_sh_q;
        per_sh_d      = per_sh_q;
        duty_sh_d     = duty_sh_q;
        inv_sh_d      = inv_sh_q;
        pending_d     = pending_q;
        pwm_d         = inv_sh_q;
        period_tick_d = 1'b0;
        update_done_d = 1'b0;

        unique case (state_q)
            StIdle: begin
                // Shadows track the inputs so the first RUN period uses current settings.
                pre_sh_d  = cfg_prescale;
                per_sh_d  = cfg_period;
                duty_sh_d = cfg_duty;
                inv_sh_d  = cfg_invert;
                pre_cnt_d = '0;
                cnt_d     = '0;
                pending_d = 1'b0;
                if (cfg_enable) begin
                    state_d = StRun;
                end
            end
            StRun: begin
                if (!cfg_enable) begin
                    state_d   = StIdle;
                    pre_cnt_d = '0;
                    cnt_d     = '0;
                    pending_d = 1'b0;
                end else begin
                    pwm_d         = active ^ inv_sh_q;
                    pre_cnt_d     = tick ? '0 : pre_cnt_q + PRE_WIDTH'(1);
                    cnt_d         = wrap ? '0 : (tick ? cnt_q + CNT_WIDTH'(1) : cnt_q);
                    period_tick_d = wrap;
                    // A strobe coinciding with the period end is honoured immediately.
                    if (wrap && (pending_q || cfg_update)) begin
                        pre_sh_d      = cfg_prescale;
                        per_sh_d      = cfg_period;
                        duty_sh_d     = cfg_duty;
                        inv_sh_d      = cfg_invert;
                        pending_d     = 1'b0;
                        update_done_d = 1'b1;
                    end else begin
                        pending_d = pending_q | cfg_update;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state_q       <= StIdle;
            pre_cnt_q     <= '0;
            cnt_q         <= '0;
            pre_sh_q      <= '0;
            per_sh_q      <= '0;
            duty_sh_q     <= '0;
            inv_sh_q      <= '0;
            pending_q     <= 1'b0;
            pwm_q         <= '0;
            period_tick_q <= 1'b0;
            update_done_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            pre_cnt_q     <= pre_cnt_d;
            cnt_q         <= cnt_d;
            pre_sh_q      <= pre_sh_d;
            per_sh_q      <= per_sh_d;
            duty_sh_q     <= duty_sh_d;
            inv_sh_q      <= inv_sh_d;
            pending_q     <= pending_d;
            pwm_q         <= pwm_d;
            period_tick_q <= period_tick_d;
            update_done_q <= update_done_d;
        end
    end

    assign pwm_out     = pwm_q;
    assign period_tick = period_tick_q;
    assign update_done = update_done_q;

endmodule

// File: doc/pwm_gen_core.md
# pwm_gen_core

PWM generator stage that sits directly downstream of the pwm_ip AXI4-Lite slave register file. It consumes the four software-written configuration registers (control, prescale/period, and duties) and drives NUM_CH PWM outputs to the board LEDs. All channels share one period counter. Duty, period and polarity pass through shadow registers, so software writes never tear a PWM period.

## Interface
- CNT_WIDTH, 16: width of the period counter, the period value and each duty value.
- NUM_CH, 4: number of PWM output channels.
- PRE_WIDTH, 8: width of the prescaler.

Ports:
- ACLK  input  1  sole clock; all logic on its rising edge.
- ARESET  input  1  asynchronous, active-high reset.
- cfg_enable  input  1  run enable (control register bit 0).
- cfg_invert  input  NUM_CH  per-channel output polarity invert.
- cfg_prescale  input  PRE_WIDTH  the counter advances once every cfg_prescale+1 ACLK cycles.
- cfg_period  input  CNT_WIDTH  counter terminal value; the period is cfg_period+1 ticks.
- cfg_duty  input  NUM_CH*CNT_WIDTH  channel i duty in bits [i*CNT_WIDTH +: CNT_WIDTH], in ticks.
- cfg_update  input  1  one-cycle strobe from the register file on any configuration write.
- pwm_out  output  NUM_CH  registered PWM outputs.
- period_tick  output  1  one-cycle pulse on each counter wrap.
- update_done  output  1  one-cycle pulse when the shadow registers load from the cfg_* inputs.

## Operation
- State machine with two states, IDLE and RUN.
- IDLE behaviour:
  - The shadow registers (prescale, period, duty, invert) reload from cfg_* every cycle.
  - The prescaler and the counter are held at 0.
  - pwm_out = invert_sh, which is the inactive level.
  - update_done and period_tick stay 0.
- IDLE -> RUN when cfg_enable=1. The counter starts at 0 on the first RUN cycle.
- RUN -> IDLE when cfg_enable=0. This takes effect immediately, mid-period included. pwm_out returns to inactive on the next edge.
- Prescaler:
  - pre_cnt counts 0..pre_sh. tick=1 when pre_cnt==pre_sh, and pre_cnt then wraps to 0.
  - pre_sh=0 gives tick every cycle.
- Counter:
  - On tick, cnt increments.
  - If cnt==per_sh on tick, cnt wraps to 0 and period_tick pulses. This is the period end.
  - per_sh=0 gives a period end on every tick.
- Channel compare: active_i = (cnt < duty_sh_i), an unsigned compare at CNT_WIDTH bits.
  - duty=0 keeps the channel always inactive.
  - duty > per_sh keeps the channel always active (100 %).
- Output: pwm_out_i <= active_i XOR invert_sh_i.
- Update handling in RUN:
  - cfg_update sets a pending flag.
  - At the next period end, if the flag is set or cfg_update is asserted in that same cycle, all shadows load from cfg_*, the flag clears, and update_done pulses.
  - Multiple strobes within one period collapse to a single load, which uses the cfg_* values present at the period end.
  - The new values apply from counter value 0 of the following period.
- cfg_update in IDLE is ignored; the shadows already track the inputs.

## Timing
- Reset values (async assert):
  - pwm_out=0, period_tick=0, update_done=0.
  - cnt=0, pre_cnt=0, all shadows 0, pending flag 0, state IDLE.
- Reset release: outputs follow the IDLE rule from the first clock edge after release.
- pwm_out latency: pwm_out reflects cnt one ACLK after cnt holds that value.
- The first rising edge of pwm_out after enable occurs 1 cycle after the first RUN cycle.
- period_tick and update_done are registered. Both assert in the cycle after the wrap edge, aligned with cnt=0 of the new period.
- Period length is (per_sh+1)*(pre_sh+1) ACLK cycles. Active time is min(duty, per_sh+1)*(pre_sh+1) cycles.
- Reset mid-period: all state clears within the same cycle, with no glitch suppression required.

## Test plan
- Basic PWM:
  - Stimulus: reset, then prescale=0, period=9, duty0=3, invert=0, enable=1.
  - Required: pwm_out[0] repeats 3 cycles high and 7 low; period_tick every 10 cycles.
- Prescaler and boundary duties:
  - Stimulus: prescale=1, period=4, duty0=0, duty1=5, duty2=2.
  - Required: ch0 is constant 0; ch1 is constant 1; ch2 is 4 cycles high per 10.
- Shadowed update:
  - Stimulus: mid-period, write duty0=8 with a cfg_update strobe, then a second strobe 2 cycles later.
  - Required:
    - The current period is unchanged.
    - Exactly one update_done occurs, at the wrap.
    - The next period is 8 high and 2 low.
- Polarity and disable:
  - Stimulus: invert[0]=1 in IDLE, then deassert enable mid-period.
  - Required:
    - pwm_out[0]=1 in IDLE.
    - In RUN, the output is the complement of the basic case.
    - After disable, pwm_out[0] returns to 1 one cycle later and cnt=0.
- Period zero: period=0, duty0=1, prescale=0 -> pwm_out[0] is constant 1 and period_tick asserts every cycle.
- Async reset mid-run: assert ARESET between clock edges while pwm_out=1 -> all outputs are 0 immediately and stay IDLE after release until enable.
